bram_rmw_initiator: RTL and testbench
=====================================

# bram_rmw_initiator

Request-side engine that drives both ports of a dual-ported BRAM (registered 1-cycle read) and executes read, write and read-modify-write add requests from a single client. It sits between a pipeline client (valid/ready request, valid/ready response) and one `dual_ported_bram` instance. Port A is used only for reads and port B only for writes. Throughput is one request per cycle, and every request returns the pre-update word.

## Interface
Parameters:
- `value_width`, 32, data word width.
- `index_width`, 8, address width; memory depth is 2**index_width.

Ports:
- `clk`  in  1  single clock for all logic and both BRAM ports.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when req_valid && req_ready at a rising edge.
- `req_op`  in  2  00 read, 01 write, 10 add, 11 treated as read.
- `req_addr`  in  index_width  target word.
- `req_data`  in  value_width  write data or add operand.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when rsp_valid && rsp_ready.
- `rsp_data`  out  value_width  word value before this request's update.
- `mem_ena`, `mem_wea`  out  1  port A enable; port A write-enable, tied 0.
- `mem_addra`  out  index_width  port A address.
- `mem_dia`  out  value_width  port A write data, tied 0.
- `mem_doa`  in  value_width  port A read data, valid the cycle after mem_ena.
- `mem_enb`, `mem_web`  out  1  port B enable and write-enable.
- `mem_addrb`  out  index_width  port B address.
- `mem_dib`  out  value_width  port B write data.

## Operation
- Stage 0 (accept): `mem_ena = req_valid && req_ready` and `mem_addra = req_addr`, both combinational. On acceptance, the op, address and data load into the stage-1 register (`s1_valid`).
- Stage 1 (modify/commit): `old = fwd_hit ? fwd_data : mem_doa`.
  - Read: no write.
  - Write: new value is `req_data`.
  - Add: new value is `old + req_data`, truncated to value_width (wraps mod 2**value_width).
- Commit occurs when `advance = s1_valid && (!rsp_valid || rsp_ready)`. In that cycle:
  - `mem_enb = mem_web = advance && op!=read`, with `mem_addrb = s1_addr` and `mem_dib = new`.
  - The response register loads `old` and sets rsp_valid.
- `req_ready = !s1_valid || advance`, additionally gated by the hazard rule under Configuration.
- Stall: while `s1_valid && !advance`, port A is idle. The BRAM holds `mem_doa`, and `fwd_hit`/`fwd_data` hold their values.
- Hazard: a read of address X in the same cycle that port B writes X returns the stale word (the BRAM is read-first). Only a request accepted in the cycle immediately after a same-address commit is affected. Later requests see the committed data.
- Reset values: req_ready 1, rsp_valid 0, rsp_data 0, s1_valid 0, fwd_hit 0, all mem_* enables 0.
  - Reset asserted mid-operation drops the in-flight op. mem_enb deasserts immediately, so no partial write occurs.
  - Memory contents are not touched by reset.

## Timing
- Request accepted in cycle 0: port A read is issued in cycle 0, and the port B write is issued in cycle 1 if not stalled.
- rsp_valid is high from cycle 2. The written word is readable by a request accepted in cycle 2 or later, or in cycle 1 via forwarding.
- Back-to-back requests with rsp_ready held high sustain 1 request/cycle, with a constant 2-cycle latency.
- With rsp_ready low and rsp_valid high: one further request is accepted into stage 1, then req_ready drops. Nothing is lost or reordered.
- Responses are returned in request order. Exactly one response is produced per accepted request.

## Configuration
- `RMW_FORWARD_EN` defined:
  - On acceptance, if `advance && mem_web && req_addr == s1_addr`, set `fwd_hit` and capture `fwd_data = mem_dib`. Otherwise clear `fwd_hit`.
  - req_ready is never dropped for hazards.
- `RMW_FORWARD_EN` undefined:
  - `fwd_hit` is constant 0.
  - req_ready is deasserted in any cycle where `advance && mem_web && req_addr == s1_addr`, inserting exactly one bubble. The request is accepted the following cycle.

## Test plan
- Reset, then write 0xDEADBEEF to addr 5, then read addr 5 → first response carries the prior content, and the read response is 0xDEADBEEF in cycle 2 of the read.
- Write 0xFFFFFFFF to addr 3, then add 2 to addr 3 → add response is 0xFFFFFFFF, and a subsequent read returns 0x00000001 (wrap).
- Back-to-back adds of 1 to addr 7 for 4 cycles, starting from 10 → responses 10, 11, 12, 13 and final read 14.
  - With the macro defined: no bubbles.
  - Without the macro: req_ready low for 1 cycle between each pair.
- rsp_ready held low for 5 cycles during a stream to addrs 0..7 → req_ready drops after 2 accepts. Responses resume in order with no duplicates, and memory holds the correct values.
- rst_n pulsed low in cycle 1 of a write of 0x55 to addr 9 (previously 0x11) → no port B write, rsp_valid 0, and a read after reset returns 0x11.
- Op 11 to addr 2 holding 0xA5 → response 0xA5 and no port B activity.

Source files
------------

// File: rtl/bram_rmw_initiator.sv
// rtl/bram_rmw_initiator.sv - two-stage read/write/add engine driving a read-first dual-ported BRAM
//
// Accepts one request per cycle from a valid/ready client and returns the
// pre-update word of every request, in order, on a valid/ready response.
// Port A of the BRAM is used only for reads, port B only for writes.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_op                        00 read, 01 write, 10 add, 11 read
//   req_addr, req_data            target word, write data / add operand
//   rsp_valid/rsp_ready, rsp_data response handshake, word before update
//   mem_ena/wea/addra/dia/doa     BRAM port A (read only, wea/dia tied 0)
//   mem_enb/web/addrb/dib         BRAM port B (write only)
//
// Build option: RMW_FORWARD_EN
//   defined   - a request to the address being committed in the same cycle
//               takes the committed word from a forwarding register.
//   undefined - such a request is held off for one cycle instead.
module bram_rmw_initiator #(
    parameter int value_width = 32,
    parameter int index_width = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [index_width-1:0] req_addr,
    input  logic [value_width-1:0] req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [value_width-1:0] rsp_data,
    output logic                   mem_ena,
    output logic                   mem_wea,
    output logic [index_width-1:0] mem_addra,
    output logic [value_width-1:0] mem_dia,
    input  logic [value_width-1:0] mem_doa,
    output logic                   mem_enb,
    output logic                   mem_web,
    output logic [index_width-1:0] mem_addrb,
    output logic [value_width-1:0] mem_dib
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    logic                   s1_valid_q, s1_valid_d;
    logic [1:0]             s1_op_q, s1_op_d;
    logic [index_width-1:0] s1_addr_q, s1_addr_d;
    logic [value_width-1:0] s1_data_q, s1_data_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [value_width-1:0] rsp_data_q, rsp_data_d;
    logic                   fwd_hit_q, fwd_hit_d;
    logic [value_width-1:0] fwd_data_q, fwd_data_d;

    logic                   advance;
    logic                   commit_wr;
    logic                   same_addr;
    logic                   accept;
    logic                   req_ready_c;
    logic [value_width-1:0] old_word;
    logic [value_width-1:0] new_word;

    always_comb begin
        advance   = s1_valid_q && (!rsp_valid_q || rsp_ready);
        commit_wr = advance && ((s1_op_q == OP_WRITE) || (s1_op_q == OP_ADD));
        // Port A would read this address in the very cycle port B writes it,
        // and the read-first BRAM would hand back the stale word.
        same_addr = commit_wr && (req_addr == s1_addr_q);
        old_word  = fwd_hit_q ? fwd_data_q : mem_doa;
        new_word  = (s1_op_q == OP_WRITE) ? s1_data_q : old_word + s1_data_q;
`ifdef RMW_FORWARD_EN
        req_ready_c = !s1_valid_q || advance;
`else
        req_ready_c = (!s1_valid_q || advance) && !same_addr;
`endif
        accept = req_valid && req_ready_c;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = req_op;
            s1_addr_d  = req_addr;
            s1_data_d  = req_data;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (advance) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = old_word;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        // Forwarding state only changes on acceptance, so it survives stalls
        // together with the BRAM output it stands in for.
        fwd_hit_d  = fwd_hit_q;
        fwd_data_d = fwd_data_q;
`ifdef RMW_FORWARD_EN
        if (accept) begin
            fwd_hit_d  = same_addr;
            fwd_data_d = new_word;
        end
`else
        fwd_hit_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign req_ready = req_ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_ena   = accept;
    assign mem_wea   = 1'b0;
    assign mem_addra = req_addr;
    assign mem_dia   = '0;
    // Derived from s1_valid_q, so an asynchronous reset drops a pending write at once.
    assign mem_enb   = commit_wr;
    assign mem_web   = commit_wr;
    assign mem_addrb = s1_addr_q;
    assign mem_dib   = new_word;

endmodule

// File: tb/tb_bram_rmw_initiator.sv
// tb/tb_bram_rmw_initiator.sv - scoreboard bench for bram_rmw_initiator with a read-first BRAM model
module tb_bram_rmw_initiator;

    localparam int VW = 32;
    localparam int IW = 8;
`ifdef RMW_FORWARD_EN
    localparam int EXP_BUBBLES = 0;
`else
    localparam int EXP_BUBBLES = 3;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [IW-1:0] req_addr = '0;
    logic [VW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [VW-1:0] rsp_data;
    logic          mem_ena, mem_wea, mem_enb, mem_web;
    logic [IW-1:0] mem_addra, mem_addrb;
    logic [VW-1:0] mem_dia, mem_dib;
    logic [VW-1:0] mem_doa;

    logic [VW-1:0] bram  [0:255];
    logic [VW-1:0] model [0:255];
    bit            mem_inited = 1'b0;
    exp_t          exp_q[$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    int            accepts = 0;
    int            stall_cycles = 0;
    int            pb_writes = 0;

    bram_rmw_initiator #(.value_width(VW), .index_width(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dia(mem_dia), .mem_doa(mem_doa),
        .mem_enb(mem_enb), .mem_web(mem_web), .mem_addrb(mem_addrb),
        .mem_dib(mem_dib)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B1) + 32'h13;
    endfunction

    // Read-first BRAM: registered port A read, port B write.
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
            mem_inited <= 1'b1;
        end else begin
            if (mem_ena) mem_doa <= bram[mem_addra];
            if (mem_enb && mem_web) bram[mem_addrb] <= mem_dib;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, waits for acceptance and records the expected response.
    task automatic send(input logic [1:0] op, input logic [7:0] addr,
                        input logic [31:0] data, input bit lat);
        int   waited = 0;
        exp_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            stall_cycles++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("req_accept_timeout", 32'd0, 32'd1);
        end else begin
            e.data = model[addr];
            e.cyc  = cyc;
            e.lat  = lat;
            exp_q.push_back(e);
            if (op == 2'b01) model[addr] = data;
            else if (op == 2'b10) model[addr] = model[addr] + data;
            accepts++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mem_enb) pb_writes++;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                if (e.lat) check("rsp_latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int pbw;
        int nbad;
        for (int i = 0; i < 256; i++) model[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mem_ena", mem_ena, 32'd0);
        check("rst_mem_enb", mem_enb, 32'd0);
        check("rst_mem_wea", mem_wea, 32'd0);
        check("rst_mem_dia", mem_dia, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then immediate read of the same word.
        send(2'b01, 8'd5, 32'hDEADBEEF, 1'b0);
        send(2'b00, 8'd5, 32'h0, 1'b1);
        drain();

        // Add wraps modulo 2**32.
        send(2'b01, 8'd3, 32'hFFFFFFFF, 1'b0);
        send(2'b10, 8'd3, 32'd2, 1'b0);
        send(2'b00, 8'd3, 32'h0, 1'b0);
        drain();

        // Back-to-back adds to one address.
        send(2'b01, 8'd7, 32'd10, 1'b0);
        drain();
        stall_cycles = 0;
        for (int k = 0; k < 4; k++) send(2'b10, 8'd7, 32'd1, 1'b1);
        check("add_bubbles", stall_cycles, EXP_BUBBLES);
        send(2'b00, 8'd7, 32'h0, 1'b0);
        drain();
        check("add_final_word", model[7], 32'd14);

        // Response backpressure during a stream.
        fork
            begin
                for (int k = 0; k < 8; k++) send(2'b01, k[7:0], 32'h100 + k, 1'b0);
            end
            begin
                a0 = accepts;
                rsp_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("bp_accepts", accepts - a0, 32'd2);
                check("bp_req_ready", req_ready, 32'd0);
                rsp_ready = 1'b1;
            end
        join
        drain();
        for (int k = 0; k < 8; k++) send(2'b00, k[7:0], 32'h0, 1'b0);
        drain();

        // Reset in the commit cycle of a write.
        send(2'b01, 8'd9, 32'h11, 1'b0);
        drain();
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 8'd9;
        req_data  = 32'h55;
        @(negedge clk);
        check("rst_mid_accept", req_ready, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_mid_enb_before", mem_enb, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_enb_after", mem_enb, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 32'd0);
        check("rst_mid_mem9", bram[9], 32'h11);
        send(2'b00, 8'd9, 32'h0, 1'b1);
        drain();

        // Op 11 behaves as a read with no port B activity.
        send(2'b01, 8'd2, 32'hA5, 1'b0);
        drain();
        pbw = pb_writes;
        send(2'b11, 8'd2, 32'h12345678, 1'b1);
        drain();
        check("op11_no_portb", pb_writes - pbw, 32'd0);

        nbad = 0;
        for (int i = 0; i < 256; i++) if (bram[i] !== model[i]) nbad++;
        check("mem_image", nbad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
